led_chain_driver: RTL

LED_CHAIN_DRIVER -- requirements
Module: led_chain_driver

---
 rtl/led_chain_driver_if.sv | 32 +++
 rtl/led_chain_driver.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/led_chain_driver_if.sv
// Host-side bundle for the LED chain driver: frame request/data in, serial chain strobes out.
interface led_chain_driver_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic [WIDTH-1:0] i_Data;
    logic             i_Load;
    logic             o_Busy;
    logic             o_Done;
    logic             o_LEDData;
    logic             o_LEDClk;
    logic             o_LEDLatch;

    modport slave (
        input  i_Data,
        input  i_Load,
        output o_Busy,
        output o_Done,
        output o_LEDData,
        output o_LEDClk,
        output o_LEDLatch
    );

    modport master (
        output i_Data,
        output i_Load,
        input  o_Busy,
        input  o_Done,
        input  o_LEDData,
        input  o_LEDClk,
        input  o_LEDLatch
    );
endinterface

// File: rtl/led_chain_driver.sv
// Serialises a WIDTH-bit frame into daisy-chained LED shift registers, then strobes the latch.
module led_chain_driver #(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned CLK_DIV      = 2,
    parameter int unsigned LATCH_CYCLES = 2,
    parameter bit          MSB_FIRST    = 1'b1,
    parameter bit          AUTO_REFRESH = 1'b0
) (
    input  logic              i_CLK,
    input  logic              i_RESET,
    led_chain_driver_if.slave bus
);

    localparam int unsigned BIT_W = $clog2(WIDTH + 1);
    localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);
    localparam int unsigned LAT_W = $clog2(LATCH_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               pend_q, pend_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [WIDTH-1:0]   shadow_q, shadow_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               data_q, data_d;
    logic               lclk_q, lclk_d;
    logic               latch_q, latch_d;

    logic               first_bit;
    logic [WIDTH-1:0]   shadow_rot;
    logic               next_bit;

    // Shadow rotates so the bit to present next always sits at the output end.
    assign first_bit  = MSB_FIRST ? bus.i_Data[WIDTH-1] : bus.i_Data[0];
    assign shadow_rot = MSB_FIRST ? {shadow_q[WIDTH-2:0], shadow_q[WIDTH-1]}
                                  : {shadow_q[0], shadow_q[WIDTH-1:1]};
    assign next_bit   = MSB_FIRST ? shadow_rot[WIDTH-1] : shadow_rot[0];

    // State and output registers.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            state_q  <= IDLE;
            pend_q   <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
            lat_q    <= '0;
            shadow_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            data_q   <= 1'b0;
            lclk_q   <= 1'b0;
            latch_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            lat_q    <= lat_d;
            shadow_q <= shadow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            data_q   <= data_d;
            lclk_q   <= lclk_d;
            latch_q  <= latch_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        div_d    = div_q;
        bit_d    = bit_q;
        lat_d    = lat_q;
        shadow_d = shadow_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        data_d   = data_q;
        lclk_d   = lclk_q;
        latch_d  = 1'b1;

        if ((state_q != IDLE) && bus.i_Load) begin
            pend_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                lclk_d = 1'b0;
                if (bus.i_Load || AUTO_REFRESH || pend_q) begin
                    state_d  = SHIFT;
                    shadow_d = bus.i_Data;
                    pend_d   = 1'b0;
                    busy_d   = 1'b1;
                    data_d   = first_bit;
                    div_d    = '0;
                    bit_d    = '0;
                end
            end

            SHIFT: begin
                if (div_q == DIV_W'(CLK_DIV - 1)) begin
                    div_d = '0;
                    if (!lclk_q) begin
                        lclk_d = 1'b1;
                    end else begin
                        lclk_d = 1'b0;
                        // Last high phase done: keep the final bit on the line into LATCH.
                        if (bit_q == BIT_W'(WIDTH - 1)) begin
                            state_d = LATCH;
                            latch_d = 1'b0;
                            bit_d   = '0;
                            lat_d   = '0;
                        end else begin
                            bit_d    = bit_q + BIT_W'(1);
                            shadow_d = shadow_rot;
                            data_d   = next_bit;
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            LATCH: begin
                if (lat_q == LAT_W'(LATCH_CYCLES - 1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    lat_d   = '0;
                end else begin
                    latch_d = 1'b0;
                    lat_d   = lat_q + LAT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                lclk_d  = 1'b0;
            end
        endcase
    end

    assign bus.o_Busy     = busy_q;
    assign bus.o_Done     = done_q;
    assign bus.o_LEDData  = data_q;
    assign bus.o_LEDClk   = lclk_q;
    assign bus.o_LEDLatch = latch_q;

endmodule
